// File: rtl/rs232_rx.sv
// RS-232 receiver: 8N1 frames at one of four baud rates chosen per frame,
// with a valid/ack holding register and frame-error / overrun pulses.
module rs232_rx #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] buad_setting,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun
);

    // Cycles per bit for each rate; the counter is sized for the slowest one.
    localparam int DIV_9600   = CLK_FREQ / 9600;
    localparam int DIV_19200  = CLK_FREQ / 19200;
    localparam int DIV_57600  = CLK_FREQ / 57600;
    localparam int DIV_115200 = CLK_FREQ / 115200;
    localparam int CNT_W      = $clog2(DIV_9600 + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] baud_q, baud_d;
    logic       rx_d_q;          // previous-cycle copy of rx for edge detection
    logic       armed_q, armed_d; // line has been seen idle since reset
    logic       load_q, load_d;  // good stop sampled; publish byte next cycle
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    cnt_t div_sel;
    cnt_t half_sel;
    logic start_edge;

    // Bit period of the rate latched at the start of the current frame.
    always_comb begin
        div_sel = cnt_t'(DIV_9600);
        case (baud_q)
            2'b00:   div_sel = cnt_t'(DIV_9600);
            2'b01:   div_sel = cnt_t'(DIV_19200);
            2'b10:   div_sel = cnt_t'(DIV_57600);
            default: div_sel = cnt_t'(DIV_115200);
        endcase
        half_sel = div_sel >> 1;
    end

    // Falling edge only counts once the line has been high after reset, so a
    // line held low through reset release cannot start a frame.
    assign start_edge = !rx && rx_d_q && armed_q;

    // Next-state logic for the frame FSM and the output holding register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + cnt_t'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        baud_d      = baud_q;
        armed_d     = armed_q | rx;
        load_d      = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (rx_valid_q && rx_ack) begin
            rx_valid_d = 1'b0;
        end

        // A new byte wins over a same-cycle ack; overrun only if it was unacked.
        if (load_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q && !rx_ack;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    state_d = START;
                    baud_d  = buad_setting;
                    bit_d   = 3'd0;
                end
            end
            START: begin
                if (cnt_q == half_sel - cnt_t'(1)) begin
                    cnt_d   = '0;
                    state_d = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == div_sel - cnt_t'(1)) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == div_sel - cnt_t'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx) begin
                        load_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            baud_q      <= 2'b00;
            rx_d_q      <= 1'b1;
            armed_q     <= 1'b0;
            load_q      <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            baud_q      <= baud_d;
            rx_d_q      <= rx;
            armed_q     <= armed_d;
            load_q      <= load_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rs232_rx.sv
// Scoreboard bench for rs232_rx: frames are serialised from a bit-level
// description, expected results queued at issue time, and a monitor checks
// every byte / frame-error event the receiver produces.
module tb_rs232_rx;

    localparam int CLK_FREQ = 1152000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] buad_setting = 2'b11;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_err;
    logic       overrun;

    logic auto_ack   = 1'b1;
    logic auto_ack_r = 1'b0;
    logic manual_ack = 1'b0;
    assign rx_ack = auto_ack ? auto_ack_r : manual_ack;

    rs232_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk(clk), .rst(rst), .buad_setting(buad_setting), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_ferr;
        logic [7:0] data;
        bit         ovr;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   ev_count = 0;
    bit   model_valid = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, expv, expv, cyc);
        end
    endtask

    function automatic int div_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return CLK_FREQ / 9600;
            2'b01:   return CLK_FREQ / 19200;
            2'b10:   return CLK_FREQ / 57600;
            default: return CLK_FREQ / 115200;
        endcase
    endfunction

    // Auto-acknowledge each byte one cycle after it appears.
    always @(negedge clk) auto_ack_r = rx_valid && !auto_ack_r;

    // Monitor: every frame error or byte publication consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (frame_err) begin
            ev_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_frame_err", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("ferr_kind", 1, int'(e.is_ferr));
                check("ferr_cycle", cyc, e.cyc);
                $display("[TB] frame_err at cycle %0d (expected %0d)", cyc, e.cyc);
            end
        end
        if ((rx_valid && !prev_valid) || overrun) begin
            ev_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("byte_kind", 0, int'(e.is_ferr));
                check("byte_data", int'(rx_data), int'(e.data));
                check("byte_overrun", int'(overrun), int'(e.ovr));
                check("byte_cycle", cyc, e.cyc);
                $display("[TB] byte 0x%02h ovr=%0b at cycle %0d (expected 0x%02h ovr=%0b cycle %0d)",
                         rx_data, overrun, cyc, e.data, e.ovr, e.cyc);
            end
        end
        prev_valid = rx_valid;
    end

    // Serialise one frame; the falling edge is detected at the next posedge.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int div);
        exp_t e;
        int   edge_cyc;
        edge_cyc  = cyc + 1;
        e.is_ferr = !stop_bit;
        e.data    = data;
        e.ovr     = 0;
        if (stop_bit) begin
            e.ovr = model_valid;
            e.cyc = edge_cyc + div / 2 + 9 * div + 1;
            if (!auto_ack) model_valid = 1;
        end else begin
            e.cyc = edge_cyc + div / 2 + 9 * div;
        end
        exp_q.push_back(e);
        rx = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (div) @(negedge clk);
        end
        rx = stop_bit;
        repeat (div) @(negedge clk);
    endtask

    task automatic idle_line(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic glitch(input int len, input int div);
        rx = 1'b0;
        repeat (len) @(negedge clk);
        rx = 1'b1;
        repeat (div + 2) @(negedge clk);
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_timeout_left", exp_q.size(), 0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"}, int'(rx_data), 0);
        check({tag, "_rx_valid"}, int'(rx_valid), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        int ev0;
        int div;
        logic [1:0] sel;
        int kind;

        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Bad stop bit: frame error, holding register untouched.
        buad_setting = 2'b11;
        send_frame(8'h3C, 1'b0, 10);
        idle_line(12);
        wait_drain();
        check("ferr_rx_valid", int'(rx_valid), 0);
        check("ferr_rx_data", int'(rx_data), 0);

        // Three-cycle glitch: no activity.
        ev0 = ev_count;
        glitch(3, 10);
        idle_line(20);
        check("glitch_events", ev_count, ev0);
        check("glitch_rx_valid", int'(rx_valid), 0);

        // Basic byte at DIV=10 (latency 96 checked by the scoreboard).
        send_frame(8'hA5, 1'b1, 10);
        idle_line(15);
        wait_drain();
        check("a5_data", int'(rx_data), 8'hA5);

        // Back-to-back without ack: second byte overruns the first.
        repeat (4) @(negedge clk);
        auto_ack = 1'b0;
        model_valid = 0;
        send_frame(8'h11, 1'b1, 10);
        send_frame(8'h22, 1'b1, 10);
        idle_line(10);
        wait_drain();
        check("ovr_rx_valid", int'(rx_valid), 1);
        check("ovr_rx_data", int'(rx_data), 8'h22);
        manual_ack = 1'b1;
        @(negedge clk);
        manual_ack = 1'b0;
        check("ack_clears_valid", int'(rx_valid), 0);
        model_valid = 0;
        auto_ack = 1'b1;
        idle_line(5);

        // Baud setting changes mid-frame must not affect the frame in flight.
        buad_setting = 2'b00;
        fork
            send_frame(8'h5A, 1'b1, 120);
            begin
                repeat (300) @(negedge clk);
                buad_setting = 2'b11;
            end
        join
        idle_line(130);
        wait_drain();

        // Reset during data bit 4, released with the line low.
        buad_setting = 2'b11;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (10) @(negedge clk);
        end
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b1;
        ev0 = ev_count;
        repeat (150) @(negedge clk);
        check("midreset_events", ev_count, ev0);
        idle_line(10);
        send_frame(8'hFF, 1'b1, 10);
        idle_line(15);
        wait_drain();

        // Randomised traffic: mixed rates, bad stops, glitches, random idle gaps.
        for (int n = 0; n < 30; n++) begin
            sel = 2'($urandom_range(1, 3));
            div = div_of(sel);
            buad_setting = sel;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                ev0 = ev_count;
                glitch($urandom_range(1, div / 2), div);
                check("rand_glitch_events", ev_count, ev0);
            end else if (kind == 1) begin
                send_frame(8'($urandom), 1'b0, div);
                idle_line(div * $urandom_range(1, 2));
            end else begin
                send_frame(8'($urandom), 1'b1, div);
                idle_line(div * $urandom_range(0, 2));
            end
        end
        idle_line(200);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
